// File: rtl/render_pkg.sv
// Shared types and constants for the render frame pipeline: sequencer states,
// default counter widths and the frame period derived from clock speed and FPS.
package render_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RENDER = 2'd2,
        SWAP   = 2'd3
    } seq_state_t;

    localparam int FRAME_CNT_W_DEF     = 16;
    localparam int OVR_CNT_W_DEF       = 8;
    localparam int SYS_CLK_SPEED       = 100_000_000;
    localparam int FPS                 = 60;
    localparam int FRAME_PERIOD_CYCLES = SYS_CLK_SPEED / FPS;

endpackage

// File: rtl/stage_watchdog.sv
// Cycle watchdog shared by the CLEAR and RENDER stages; expire marks the
// TIMEOUT-th enabled cycle since the last load. TIMEOUT=0 never expires.
module stage_watchdog #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last   = (cnt_q == CW'(TIMEOUT - 1));
    assign expire = (TIMEOUT > 0) && enable && last;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && !last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: turns rising edges of the frame tick into clear -> render -> swap.
// Optional macro FRAME_STATS_EN adds last/max frame-length statistics ports.
module frame_sequencer
    import render_pkg::*;
#(
    parameter int FRAME_CNT_W   = FRAME_CNT_W_DEF,
    parameter int OVR_CNT_W     = OVR_CNT_W_DEF,
    parameter int STAGE_TIMEOUT = 0
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   update,
    output logic                   clear_req,
    input  logic                   clear_done,
    output logic                   render_req,
    input  logic                   render_done,
    output logic                   swap,
    output logic                   front_buf,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [OVR_CNT_W-1:0]   overrun_count,
    output logic                   timeout_err,
    output seq_state_t             dbg_state
`ifdef FRAME_STATS_EN
    ,
    output logic [31:0]            last_frame_cycles,
    output logic [31:0]            max_frame_cycles
`endif
);

    seq_state_t             state_q, state_d;
    logic                   update_q, pending_q, pending_d;
    logic                   front_q, front_d, tout_q, tout_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic [OVR_CNT_W-1:0]   ovr_q, ovr_d;
    logic                   tick, ovr_inc;
    logic                   wd_load, wd_enable, wd_expire;

    assign tick = update & ~update_q;

    // Handshake: a req stays high from stage entry until its done pulse is
    // sampled (or the watchdog fires); done outside its own stage is ignored.
    assign clear_req     = (state_q == CLEAR);
    assign render_req    = (state_q == RENDER);
    assign swap          = (state_q == SWAP);
    assign busy          = (state_q != IDLE);
    assign front_buf     = front_q;
    assign frame_count   = frame_q;
    assign overrun_count = ovr_q;
    assign timeout_err   = tout_q;
    assign dbg_state     = state_q;

    assign wd_enable = (state_q == CLEAR) || (state_q == RENDER);
    assign wd_load   = (state_d != state_q) && ((state_d == CLEAR) || (state_d == RENDER));

    stage_watchdog #(
        .TIMEOUT(STAGE_TIMEOUT)
    ) u_wd (
        .clk   (sysclk),
        .rst   (reset),
        .load  (wd_load),
        .enable(wd_enable),
        .expire(wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        front_d   = front_q;
        frame_d   = frame_q;
        ovr_d     = ovr_q;
        tout_d    = tout_q;
        ovr_inc   = 1'b0;

        // One frame may queue behind the active one; further ticks are dropped.
        if (tick && (state_q != IDLE)) begin
            if (pending_q) begin
                ovr_inc = 1'b1;
            end else if (state_q != SWAP) begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (tick) state_d = CLEAR;
            end
            CLEAR: begin
                if (clear_done) begin
                    state_d = RENDER;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    tout_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            RENDER: begin
                if (render_done) begin
                    state_d = SWAP;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    tout_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            SWAP: begin
                front_d   = ~front_q;
                frame_d   = frame_q + FRAME_CNT_W'(1);
                pending_d = 1'b0;
                state_d   = (pending_q || tick) ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ovr_inc && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            update_q  <= 1'b0;
            pending_q <= 1'b0;
            front_q   <= 1'b0;
            frame_q   <= '0;
            ovr_q     <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            update_q  <= update;
            pending_q <= pending_d;
            front_q   <= front_d;
            frame_q   <= frame_d;
            ovr_q     <= ovr_d;
            tout_q    <= tout_d;
        end
    end

`ifdef FRAME_STATS_EN
    logic [31:0] stat_cnt_q, stat_cnt_d, stat_inc;
    logic [31:0] last_q, last_d, max_q, max_d;

    assign last_frame_cycles = last_q;
    assign max_frame_cycles  = max_q;

    // stat_inc is the length of the frame so far, including the current cycle.
    always_comb begin
        stat_inc   = (stat_cnt_q == '1) ? stat_cnt_q : stat_cnt_q + 32'd1;
        stat_cnt_d = stat_cnt_q;
        last_d     = last_q;
        max_d      = max_q;
        if (state_q != IDLE) stat_cnt_d = stat_inc;
        if (state_q == SWAP) begin
            last_d = stat_inc;
            if (stat_inc > max_q) max_d = stat_inc;
        end
        if ((state_d == CLEAR) && (state_q != CLEAR)) stat_cnt_d = '0;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            stat_cnt_q <= '0;
            last_q     <= '0;
            max_q      <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
            last_q     <= last_d;
            max_q      <= max_d;
        end
    end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed scenarios plus randomized
// frames checked against a frame-level model of ticks, overruns and swaps.
module tb_frame_sequencer;

    localparam int FCW      = 4;
    localparam int OCW      = 4;
    localparam int TIMEOUT  = 16;
    localparam int OVR_MAX  = (1 << OCW) - 1;

    logic            sysclk;
    logic            reset;
    logic            update;
    logic            clear_req;
    logic            clear_done;
    logic            render_req;
    logic            render_done;
    logic            swap;
    logic            front_buf;
    logic            busy;
    logic [FCW-1:0]  frame_count;
    logic [OCW-1:0]  overrun_count;
    logic            timeout_err;
    render_pkg::seq_state_t dbg_state;
`ifdef FRAME_STATS_EN
    logic [31:0]     last_frame_cycles;
    logic [31:0]     max_frame_cycles;
`endif

    int errors = 0;
    int checks = 0;

    // Frame-level reference model
    logic           exp_front;
    logic [FCW-1:0] exp_frames;
    int             exp_ovr;
    logic           exp_pending;
    logic [FCW-1:0] exp_q[$];

    frame_sequencer #(
        .FRAME_CNT_W  (FCW),
        .OVR_CNT_W    (OCW),
        .STAGE_TIMEOUT(TIMEOUT)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .update       (update),
        .clear_req    (clear_req),
        .clear_done   (clear_done),
        .render_req   (render_req),
        .render_done  (render_done),
        .swap         (swap),
        .front_buf    (front_buf),
        .busy         (busy),
        .frame_count  (frame_count),
        .overrun_count(overrun_count),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
`ifdef FRAME_STATS_EN
        ,
        .last_frame_cycles(last_frame_cycles),
        .max_frame_cycles (max_frame_cycles)
`endif
    );

    // Clock / reset
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic model_reset();
        exp_front   = 1'b0;
        exp_frames  = '0;
        exp_ovr     = 0;
        exp_pending = 1'b0;
        exp_q.delete();
    endtask

    // Driver tasks: all start and end on a falling edge
    task automatic tick_pulse();
        update = 1'b1;
        @(negedge sysclk);
        update = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic start_frame();
        update = 1'b1;
        @(negedge sysclk);
        checks++;
        if (clear_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: clear_req=%b busy=%b required 1 1", clear_req, busy);
        end
        update = 1'b0;
        @(negedge sysclk);
    endtask

    // Completes a frame already in CLEAR, injecting ticks into both stages.
    task automatic run_frame(input int nt_c, input int cd, input int nt_r, input int rd);
        int nt;
        logic [FCW-1:0] want_cnt;
        repeat (nt_c) tick_pulse();
        repeat (cd) @(negedge sysclk);
        clear_done = 1'b1;
        @(negedge sysclk);
        clear_done = 1'b0;
        checks++;
        if (render_req !== 1'b1 || clear_req !== 1'b0) begin
            errors++;
            $display("FAIL stage_handoff: render_req=%b clear_req=%b required 1 0", render_req, clear_req);
        end
        repeat (nt_r) tick_pulse();
        repeat (rd) @(negedge sysclk);
        render_done = 1'b1;
        @(negedge sysclk);
        render_done = 1'b0;
        checks++;
        if (swap !== 1'b1 || front_buf !== exp_front) begin
            errors++;
            $display("FAIL swap_strobe: swap=%b front_buf=%b required 1 %b", swap, front_buf, exp_front);
        end
        nt = nt_c + nt_r;
        exp_front = ~exp_front;
        exp_q.push_back(exp_frames + FCW'(1));
        exp_frames = exp_frames + FCW'(1);
        if (nt > 1) exp_ovr = (exp_ovr + nt - 1 > OVR_MAX) ? OVR_MAX : exp_ovr + nt - 1;
        exp_pending = (nt > 0);
        @(negedge sysclk);
        want_cnt = exp_q.pop_front();
        checks++;
        if (frame_count !== want_cnt) begin
            errors++;
            $display("FAIL frame_count: got %0d required %0d", frame_count, want_cnt);
        end
        checks++;
        if (overrun_count !== OCW'(exp_ovr)) begin
            errors++;
            $display("FAIL overrun_count: got %0d required %0d", overrun_count, exp_ovr);
        end
        checks++;
        if (swap !== 1'b0 || front_buf !== exp_front || busy !== exp_pending || clear_req !== exp_pending) begin
            errors++;
            $display("FAIL after_swap: swap=%b front=%b busy=%b clear_req=%b required 0 %b %b %b",
                     swap, front_buf, busy, clear_req, exp_front, exp_pending, exp_pending);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; update = 1'b0; clear_done = 1'b0; render_done = 1'b0;
        model_reset();
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        checks++;
        if ({clear_req, render_req, swap, front_buf, busy, timeout_err, frame_count, overrun_count} !== '0
            || dbg_state !== render_pkg::IDLE) begin
            errors++;
            $display("FAIL reset_state: outputs=%b state=%0d required all 0", {clear_req, render_req, swap,
                     front_buf, busy, timeout_err, frame_count, overrun_count}, dbg_state);
        end
    endtask

    task automatic test_basic_frame();
        start_frame();
        repeat (3) @(negedge sysclk);
        run_frame(0, 0, 0, 9);
    endtask

    task automatic test_held_update();
        update = 1'b1;
        @(negedge sysclk);
        repeat (2) @(negedge sysclk);
        run_frame(0, 1, 0, 2);
        repeat (90) @(negedge sysclk);
        checks++;
        if (busy !== 1'b0 || overrun_count !== OCW'(0) || frame_count !== exp_frames) begin
            errors++;
            $display("FAIL held_update: busy=%b overrun=%0d frames=%0d required 0 0 %0d",
                     busy, overrun_count, frame_count, exp_frames);
        end
        update = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_three_ticks();
        start_frame();
        run_frame(0, 2, 3, 1);
        run_frame(0, 1, 0, 1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 12; f++) begin
            if (!exp_pending) start_frame();
            run_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        if (exp_pending) run_frame(0, 0, 0, 0);
    endtask

    task automatic test_overrun_saturation();
        for (int f = 0; f < 4; f++) begin
            if (!exp_pending) start_frame();
            run_frame(0, 0, 6, 0);
        end
        if (exp_pending) run_frame(0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int hi;
        update = 1'b1;
        @(negedge sysclk);
        update = 1'b0;
        hi = 0;
        while (clear_req === 1'b1 && hi < 40) begin
            hi++;
            @(negedge sysclk);
        end
        checks++;
        if (hi != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len: clear_req high %0d cycles required %0d", hi, TIMEOUT);
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || frame_count !== exp_frames || front_buf !== exp_front) begin
            errors++;
            $display("FAIL timeout_state: err=%b busy=%b frames=%0d front=%b required 1 0 %0d %b",
                     timeout_err, busy, frame_count, front_buf, exp_frames, exp_front);
        end
        clear_done = 1'b1; render_done = 1'b1;
        @(negedge sysclk);
        clear_done = 1'b0; render_done = 1'b0;
        @(negedge sysclk);
        checks++;
        if (busy !== 1'b0 || swap !== 1'b0 || frame_count !== exp_frames || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_done: busy=%b swap=%b frames=%0d err=%b required 0 0 %0d 1",
                     busy, swap, frame_count, timeout_err, exp_frames);
        end
    endtask

    task automatic test_reset_mid_render();
        start_frame();
        clear_done = 1'b1;
        @(negedge sysclk);
        clear_done = 1'b0;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        #1;
        checks++;
        if ({clear_req, render_req, swap, front_buf, busy, timeout_err, frame_count, overrun_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs=%b required all 0", {clear_req, render_req, swap,
                     front_buf, busy, timeout_err, frame_count, overrun_count});
        end
        model_reset();
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        render_done = 1'b1;
        @(negedge sysclk);
        render_done = 1'b0;
        @(negedge sysclk);
        checks++;
        if ({clear_req, render_req, swap, front_buf, busy, timeout_err, frame_count, overrun_count} !== '0
            || dbg_state !== render_pkg::IDLE) begin
            errors++;
            $display("FAIL done_after_reset: outputs=%b state=%0d required all 0", {clear_req, render_req,
                     swap, front_buf, busy, timeout_err, frame_count, overrun_count}, dbg_state);
        end
    endtask

`ifdef FRAME_STATS_EN
    task automatic stats_frame(input int c, input int r);
        update = 1'b1;
        @(negedge sysclk);
        update = 1'b0;
        repeat (c - 1) @(negedge sysclk);
        clear_done = 1'b1;
        @(negedge sysclk);
        clear_done = 1'b0;
        repeat (r - 1) @(negedge sysclk);
        render_done = 1'b1;
        @(negedge sysclk);
        render_done = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic test_frame_stats();
        stats_frame(8, 11);
        checks++;
        if (last_frame_cycles !== 32'd20 || max_frame_cycles !== 32'd20) begin
            errors++;
            $display("FAIL stats_first: last=%0d max=%0d required 20 20", last_frame_cycles, max_frame_cycles);
        end
        stats_frame(5, 6);
        checks++;
        if (last_frame_cycles !== 32'd12 || max_frame_cycles !== 32'd20) begin
            errors++;
            $display("FAIL stats_second: last=%0d max=%0d required 12 20", last_frame_cycles, max_frame_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_held_update();
        test_three_ticks();
        test_random_frames();
        test_overrun_saturation();
        test_timeout();
        test_reset_mid_render();
`ifdef FRAME_STATS_EN
        test_frame_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Consumer end of the frame tick: takes the `update` output of the frame clock generator, detects each frame tick, and sequences one render frame.
- Frame sequence: clear back buffer -> render scene -> swap front/back buffers.
- Sits between the frame clock and the clear/raster engines. Owns buffer-select state, frame counting and overrun accounting.

Parameters:
- FRAME_CNT_W, 16, width of frame_count (wraps).
- OVR_CNT_W, 8, width of overrun_count (saturates).
- STAGE_TIMEOUT, 0, max cycles a stage request may stay unacknowledged; 0 = watchdog disabled.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- update  in  1  frame tick from the frame clock; pulse or square wave; only rising edges count.
- clear_req  out  1  request to clear engine; held until clear_done.
- clear_done  in  1  clear engine completion, 1-cycle pulse.
- render_req  out  1  request to raster engine; held until render_done.
- render_done  in  1  raster completion, 1-cycle pulse.
- swap  out  1  1-cycle buffer-swap strobe.
- front_buf  out  1  index of displayed buffer; back buffer = ~front_buf.
- busy  out  1  high whenever state != IDLE.
- frame_count  out  FRAME_CNT_W  completed frames.
- overrun_count  out  OVR_CNT_W  ticks dropped.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, update_q=0, pending=0.
- Tick detect: tick = update & ~update_q, with update_q registered each cycle. A level held high counts once only.
- State transitions:
  - IDLE: tick -> CLEAR. clear_req=1 in the cycle after the tick is sampled (1-cycle latency).
  - CLEAR: clear_req=1. On clear_done -> RENDER; clear_req drops and render_req rises in the next cycle.
  - RENDER: render_req=1. On render_done -> SWAP.
  - SWAP: exactly one cycle. swap=1; front_buf toggles at the end of the cycle; frame_count increments (wraps).
  - SWAP exit: if pending, or tick in this cycle -> CLEAR and pending cleared; else -> IDLE.
- Done handling: done inputs are ignored unless the matching req is high. clear_done and render_done in the same cycle: only the one matching the current state counts.
- Overrun (tick while state != IDLE):
  - pending=0: set pending=1.
  - pending=1: overrun_count increments, saturating at all-ones.
  - Queue depth is exactly one frame.
- Watchdog (STAGE_TIMEOUT>0): counts cycles in CLEAR or RENDER; reloads on stage entry.
  - On reaching STAGE_TIMEOUT without done: drop the req, go to IDLE, set timeout_err, no swap, frame_count unchanged, pending cleared.
  - timeout_err clears only on reset.
- Reset mid-frame: immediate abort, every output to its reset value; a done arriving after reset is ignored.

Optional Feature:
- Macro: FRAME_STATS_EN.
- When defined:
  - Adds outputs last_frame_cycles[31:0] and max_frame_cycles[31:0].
  - Counter runs from the CLEAR entry cycle through the SWAP cycle inclusive, saturating at all-ones.
  - last_frame_cycles is loaded in SWAP. max_frame_cycles is updated when the new value is greater.
  - Both reset to 0.
- When undefined: ports and counter absent; all other behaviour identical.

Decomposition:
- Shared package render_pkg:
  - seq_state_t enum {IDLE, CLEAR, RENDER, SWAP}.
  - Default width constants.
  - The SYS_CLK_SPEED/FPS-derived FRAME_PERIOD_CYCLES localparam.
- One sub-module: stage_watchdog (load, enable, expire), instantiated once and shared by CLEAR and RENDER.

Test Plan:
- Reset, one update pulse, clear_done 5 cycles after clear_req, render_done 10 cycles after render_req -> one swap pulse, front_buf 0->1, frame_count=1, busy low after SWAP.
- update held high 100 cycles -> exactly one frame started; overrun_count=0.
- Three ticks during one RENDER -> pending set, overrun_count=2, next frame enters CLEAR directly from SWAP.
- STAGE_TIMEOUT=16, clear_done never asserted -> clear_req drops after 16 cycles, timeout_err=1, frame_count unchanged, state IDLE.
- reset asserted mid-RENDER, then render_done pulse -> all outputs 0; the done pulse has no effect.
- FRAME_STATS_EN, frames of 20 then 12 cycles -> last_frame_cycles=12, max_frame_cycles=20.
